pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter NSTG, default 3, meaning the number of tracked stages after decode (stage 1 = EX, stage NSTG = WB); legal range 2..7.
REQ-002 Parameter RA_W, default 5, meaning the register-address width.
REQ-003 Parameter SEL_W, default $clog2(NSTG+1), meaning the forward-select width.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 id_valid  in  1  decode slot holds a real instruction.
REQ-007 id_rs1, id_rs2, id_rd  in  RA_W each  decode source and destination registers.
REQ-008 id_use_rs1, id_use_rs2  in  1 each  decode instruction reads rs1 / rs2.
REQ-009 id_regwrite, id_memread  in  1 each  decode instruction writes rd / is a load.
REQ-010 ex_redirect  in  1  taken branch or jump resolved in stage 1.
REQ-011 mem_busy  in  1  multi-cycle memory access; freezes the whole pipe.
REQ-012 pc_hold  out  1  hold the PC and the IF/ID register.
REQ-013 id_kill  out  1  flush the IF/ID register to a NOP.
REQ-014 ex_bubble  out  1  load a NOP into ID/EX this cycle.
REQ-015 fwd_a, fwd_b  out  SEL_W each  EX operand source: 0 = register file, k = stage k (2..NSTG).
REQ-016 stg_valid  out  NSTG  per-stage valid bits, bit k-1 = stage k.
REQ-017 lu_cnt, fl_cnt  out  16 each  saturating counts of load-use bubbles and redirect flushes.

Function
REQ-018 Per stage k, keep a shadow entry: valid, rd, regwrite, memread; stage 1 also keeps rs1, rs2, use_rs1 and use_rs2.
REQ-019 load_use = s1.valid & s1.memread & s1.rd!=0 & id_valid & ((id_use_rs1 & id_rs1==s1.rd) | (id_use_rs2 & id_rs2==s1.rd)).
REQ-020 redirect = ex_redirect & s1.valid; ex_redirect with s1.valid=0 is ignored.
REQ-021 Event priority is mem_busy > redirect > load_use.
REQ-022 mem_busy=1:
  - all shadow entries hold;
  - pc_hold=1, id_kill=0, ex_bubble=0;
  - counters hold.
REQ-023 Redirect (no mem_busy):
  - id_kill=1, ex_bubble=1, pc_hold=0;
  - stage 1 next = bubble; stages k>1 shift;
  - fl_cnt increments.
REQ-024 Load_use (no mem_busy, no redirect):
  - pc_hold=1, ex_bubble=1, id_kill=0;
  - stage 1 next = bubble; stages k>1 shift;
  - lu_cnt increments.
REQ-025 Otherwise:
  - stage 1 next = decode fields with valid=id_valid;
  - stage k next = stage k-1;
  - all control outputs 0.
REQ-026 A bubble is valid=0 with regwrite=0 and memread=0; the rd/rs fields are don't-care.
REQ-027 pc_hold, id_kill, ex_bubble, fwd_a and fwd_b are combinational from current state and inputs, with zero-cycle latency.
REQ-028 fwd_a = smallest k in 2..NSTG with sk.valid & sk.regwrite & sk.rd!=0 & sk.rd==s1.rs1 & s1.use_rs1, else 0; fwd_b is the same using rs2.
REQ-029 fwd_a = fwd_b = 0 whenever s1.valid=0.
REQ-030 Register x0 never produces a forward or a load-use stall.
REQ-031 lu_cnt and fl_cnt saturate at 0xFFFF and never wrap.
REQ-032 stg_valid reflects the registered shadow valid bits, one cycle after entry.

Reset
REQ-033 While reset=1 at a clock edge:
  - all shadow entries clear to bubble;
  - lu_cnt=0, fl_cnt=0;
  - reset takes priority over mem_busy, redirect and load_use.
REQ-034 After reset: stg_valid=0, fwd_a=fwd_b=0, and pc_hold=id_kill=ex_bubble=0 when inputs are idle.
REQ-035 Reset asserted mid-stall or mid-freeze discards all in-flight entries with no counter update.

Verification
REQ-036 Sequence of load x5 then a decode reading rs1=x5 -> one cycle with pc_hold=1 and ex_bubble=1; the next cycle fwd_a=3 (NSTG=3); lu_cnt=1.
REQ-037 Back-to-back writes to x7 in stages 2 and 3 with EX rs2=x7 -> fwd_b=2 (nearest stage wins).
REQ-038 ex_redirect=1 with s1 valid and a simultaneous load_use -> id_kill=1, ex_bubble=1, pc_hold=0; fl_cnt=1 and lu_cnt unchanged.
REQ-039 mem_busy held 4 cycles during a load_use -> stg_valid constant, pc_hold=1, no counter change; load_use is resolved after release.
REQ-040 Writes to rd=x0 in every stage with rs1=rs2=0 -> fwd_a=fwd_b=0 and no stall.
REQ-041 Force 65536 load-use events, then one more -> lu_cnt=0xFFFF; then reset -> lu_cnt=0 and stg_valid=0 on the next cycle.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bus between the decode/execute datapath and pipe_hazard_ctrl.
//   master : the pipeline datapath. It drives the decode slot fields, ex_redirect
//            and mem_busy, and samples the stall, flush and forward controls.
//   slave  : pipe_hazard_ctrl. It consumes the decode fields and produces
//            pc_hold, id_kill, ex_bubble, fwd_a/fwd_b, stg_valid and the
//            lu_cnt/fl_cnt event counters.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned NSTG  = 3,
    parameter int unsigned RA_W  = 5,
    parameter int unsigned SEL_W = $clog2(NSTG + 1)
);
    logic            id_valid;
    logic [RA_W-1:0] id_rs1;
    logic [RA_W-1:0] id_rs2;
    logic [RA_W-1:0] id_rd;
    logic            id_use_rs1;
    logic            id_use_rs2;
    logic            id_regwrite;
    logic            id_memread;
    logic            ex_redirect;
    logic            mem_busy;

    logic             pc_hold;
    logic             id_kill;
    logic             ex_bubble;
    logic [SEL_W-1:0] fwd_a;
    logic [SEL_W-1:0] fwd_b;
    logic [NSTG-1:0]  stg_valid;
    logic [15:0]      lu_cnt;
    logic [15:0]      fl_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
               id_regwrite, id_memread, ex_redirect, mem_busy,
        input  pc_hold, id_kill, ex_bubble, fwd_a, fwd_b, stg_valid, lu_cnt, fl_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
               id_regwrite, id_memread, ex_redirect, mem_busy,
        output pc_hold, id_kill, ex_bubble, fwd_a, fwd_b, stg_valid, lu_cnt, fl_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller. It keeps a shadow copy of each stage after decode
// (stage 1 = EX ... stage NSTG = WB) and uses it to decide load-use stalls,
// redirect flushes, memory freezes and EX operand forwarding.
// Ports:
//   clk   : clock. All state updates on the rising edge.
//   reset : synchronous, active-high reset. All shadow entries become bubbles
//           and both counters clear.
//   bus   : pipe_hazard_ctrl_if slave. Decode fields, ex_redirect and mem_busy
//           come in; pc_hold, id_kill, ex_bubble, fwd_a/b, stg_valid and
//           lu_cnt/fl_cnt go out.
module pipe_hazard_ctrl #(
    parameter int unsigned NSTG  = 3,
    parameter int unsigned RA_W  = 5,
    parameter int unsigned SEL_W = $clog2(NSTG + 1)
) (
    input logic               clk,
    input logic               reset,
    pipe_hazard_ctrl_if.slave bus
);

    // Shadow state. Index k-1 holds stage k.
    logic [NSTG-1:0]           valid_q, valid_d;
    logic [NSTG-1:0]           regwrite_q, regwrite_d;
    logic [NSTG-1:0]           memread_q, memread_d;
    logic [NSTG-1:0][RA_W-1:0] rd_q, rd_d;
    // Source operands, kept for stage 1 only.
    logic [RA_W-1:0]           rs1_q, rs1_d;
    logic [RA_W-1:0]           rs2_q, rs2_d;
    logic                      use_rs1_q, use_rs1_d;
    logic                      use_rs2_q, use_rs2_d;
    logic [15:0]               lu_cnt_q, lu_cnt_d;
    logic [15:0]               fl_cnt_q, fl_cnt_d;

    logic             redirect;
    logic             load_use;
    logic             pc_hold_c;
    logic             id_kill_c;
    logic             ex_bubble_c;
    logic [SEL_W-1:0] fwd_a_c;
    logic [SEL_W-1:0] fwd_b_c;

    // The load flag of the last stage is never consulted, because nothing
    // shifts out of it.
    logic unused_memread;
    assign unused_memread = memread_q[NSTG-1];

    // Hazard detection. Register x0 never creates a load-use stall.
    always_comb begin
        redirect = bus.ex_redirect & valid_q[0];
        load_use = valid_q[0] & memread_q[0] & (rd_q[0] != '0) & bus.id_valid &
                   ((bus.id_use_rs1 & (bus.id_rs1 == rd_q[0])) |
                    (bus.id_use_rs2 & (bus.id_rs2 == rd_q[0])));
    end

    // Control outputs. The priority is mem_busy, then redirect, then load_use.
    always_comb begin
        pc_hold_c   = 1'b0;
        id_kill_c   = 1'b0;
        ex_bubble_c = 1'b0;
        if (bus.mem_busy) begin
            pc_hold_c = 1'b1;
        end else if (redirect) begin
            id_kill_c   = 1'b1;
            ex_bubble_c = 1'b1;
        end else if (load_use) begin
            pc_hold_c   = 1'b1;
            ex_bubble_c = 1'b1;
        end
    end

    // Forwarding. The scan runs from the oldest stage to the nearest, so the
    // smallest matching stage number is the one that remains.
    always_comb begin
        fwd_a_c = '0;
        fwd_b_c = '0;
        if (valid_q[0]) begin
            for (int k = int'(NSTG) - 1; k >= 1; k--) begin
                if (valid_q[k] && regwrite_q[k] && (rd_q[k] != '0)) begin
                    if (use_rs1_q && (rd_q[k] == rs1_q)) fwd_a_c = SEL_W'(k + 1);
                    if (use_rs2_q && (rd_q[k] == rs2_q)) fwd_b_c = SEL_W'(k + 1);
                end
            end
        end
    end

    // Next state. While mem_busy is high, every register holds.
    always_comb begin
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        memread_d  = memread_q;
        rd_d       = rd_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        use_rs1_d  = use_rs1_q;
        use_rs2_d  = use_rs2_q;
        lu_cnt_d   = lu_cnt_q;
        fl_cnt_d   = fl_cnt_q;
        if (!bus.mem_busy) begin
            for (int k = 1; k < int'(NSTG); k++) begin
                valid_d[k]    = valid_q[k-1];
                regwrite_d[k] = regwrite_q[k-1];
                memread_d[k]  = memread_q[k-1];
                rd_d[k]       = rd_q[k-1];
            end
            // The register fields are loaded on every advance. A bubble only
            // needs its valid, regwrite, memread and use flags cleared.
            rd_d[0] = bus.id_rd;
            rs1_d   = bus.id_rs1;
            rs2_d   = bus.id_rs2;
            if (redirect || load_use) begin
                valid_d[0]    = 1'b0;
                regwrite_d[0] = 1'b0;
                memread_d[0]  = 1'b0;
                use_rs1_d     = 1'b0;
                use_rs2_d     = 1'b0;
            end else begin
                valid_d[0]    = bus.id_valid;
                regwrite_d[0] = bus.id_regwrite;
                memread_d[0]  = bus.id_memread;
                use_rs1_d     = bus.id_use_rs1;
                use_rs2_d     = bus.id_use_rs2;
            end
            if (redirect) begin
                if (fl_cnt_q != 16'hFFFF) fl_cnt_d = fl_cnt_q + 16'd1;
            end else if (load_use) begin
                if (lu_cnt_q != 16'hFFFF) lu_cnt_d = lu_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= '0;
            regwrite_q <= '0;
            memread_q  <= '0;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            use_rs1_q  <= 1'b0;
            use_rs2_q  <= 1'b0;
            lu_cnt_q   <= '0;
            fl_cnt_q   <= '0;
        end else begin
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            rd_q       <= rd_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            use_rs1_q  <= use_rs1_d;
            use_rs2_q  <= use_rs2_d;
            lu_cnt_q   <= lu_cnt_d;
            fl_cnt_q   <= fl_cnt_d;
        end
    end

    assign bus.pc_hold   = pc_hold_c;
    assign bus.id_kill   = id_kill_c;
    assign bus.ex_bubble = ex_bubble_c;
    assign bus.fwd_a     = fwd_a_c;
    assign bus.fwd_b     = fwd_b_c;
    assign bus.stg_valid = valid_q;
    assign bus.lu_cnt    = lu_cnt_q;
    assign bus.fl_cnt    = fl_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl. It uses directed scenarios plus
// randomized traffic, and compares the DUT against an instruction-level pipeline
// model.
module tb_pipe_hazard_ctrl;
    localparam int NSTG  = 3;
    localparam int RA_W  = 5;
    localparam int SEL_W = $clog2(NSTG + 1);
    localparam int VW    = 3 + 2 * SEL_W + NSTG + 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.NSTG(NSTG), .RA_W(RA_W), .SEL_W(SEL_W)) bus ();

    pipe_hazard_ctrl #(.NSTG(NSTG), .RA_W(RA_W), .SEL_W(SEL_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit valid;
        int rd;
        int rs1;
        int rs2;
        bit u1;
        bit u2;
        bit rw;
        bit mr;
    } ins_t;

    ins_t mp [1:NSTG];
    int   m_lu;
    int   m_fl;
    int   compared   = 0;
    int   mismatched = 0;

    function automatic ins_t id_ins();
        ins_t d;
        d.valid = bus.id_valid;
        d.rd    = int'(bus.id_rd);
        d.rs1   = int'(bus.id_rs1);
        d.rs2   = int'(bus.id_rs2);
        d.u1    = bus.id_use_rs1;
        d.u2    = bus.id_use_rs2;
        d.rw    = bus.id_regwrite;
        d.mr    = bus.id_memread;
        return d;
    endfunction

    function automatic bit m_redirect();
        return bus.ex_redirect && mp[1].valid;
    endfunction

    function automatic bit m_load_use();
        ins_t d = id_ins();
        return mp[1].valid && mp[1].mr && mp[1].rd != 0 && d.valid &&
               ((d.u1 && d.rs1 == mp[1].rd) || (d.u2 && d.rs2 == mp[1].rd));
    endfunction

    function automatic int m_fwd(input bit second);
        int src = second ? mp[1].rs2 : mp[1].rs1;
        bit use_it = second ? mp[1].u2 : mp[1].u1;
        if (!mp[1].valid || !use_it) return 0;
        for (int k = 2; k <= NSTG; k++)
            if (mp[k].valid && mp[k].rw && mp[k].rd != 0 && mp[k].rd == src) return k;
        return 0;
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        bit busy = bus.mem_busy;
        bit r = !busy && m_redirect();
        bit l = !busy && !r && m_load_use();
        logic [NSTG-1:0] sv;
        for (int k = 1; k <= NSTG; k++) sv[k-1] = mp[k].valid;
        return {busy || l, r, r || l, SEL_W'(m_fwd(1'b0)), SEL_W'(m_fwd(1'b1)), sv,
                16'(m_lu), 16'(m_fl)};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {bus.pc_hold, bus.id_kill, bus.ex_bubble, bus.fwd_a, bus.fwd_b,
                bus.stg_valid, bus.lu_cnt, bus.fl_cnt};
    endfunction

    // Advances one clock. The model is updated from the inputs that are stable
    // at the edge, and the task returns on the following falling edge.
    task automatic step();
        ins_t nxt [1:NSTG];
        ins_t bub = '{default: 0};
        int nlu = m_lu;
        int nfl = m_fl;
        bit r;
        bit l;
        nxt = mp;
        if (reset) begin
            for (int k = 1; k <= NSTG; k++) nxt[k] = bub;
            nlu = 0;
            nfl = 0;
        end else if (!bus.mem_busy) begin
            r = m_redirect();
            l = !r && m_load_use();
            for (int k = NSTG; k >= 2; k--) nxt[k] = mp[k-1];
            nxt[1] = (r || l) ? bub : id_ins();
            if (r && nfl < 65535) nfl++;
            if (l && nlu < 65535) nlu++;
        end
        @(posedge clk);
        mp   = nxt;
        m_lu = nlu;
        m_fl = nfl;
        @(negedge clk);
    endtask

    task automatic drive_id(input bit v, input int rd, input int rs1, input int rs2,
                            input bit u1, input bit u2, input bit rw, input bit mr);
        bus.id_valid    = v;
        bus.id_rd       = RA_W'(rd);
        bus.id_rs1      = RA_W'(rs1);
        bus.id_rs2      = RA_W'(rs2);
        bus.id_use_rs1  = u1;
        bus.id_use_rs2  = u2;
        bus.id_regwrite = rw;
        bus.id_memread  = mr;
    endtask

    task automatic set_ctl(input bit redir, input bit busy);
        bus.ex_redirect = redir;
        bus.mem_busy    = busy;
    endtask

    task automatic idle();
        drive_id(0, 0, 0, 0, 0, 0, 0, 0);
        set_ctl(0, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_id(1, 5, 5, 5, 1, 1, 1, 1);
        set_ctl(1, 0);
        step();
        step();
        reset = 1'b0;
        idle();
        #1;
        compared++;
        if (bus.stg_valid !== '0) begin
            mismatched++;
            $display("FAIL reset_stg_valid got %b want 0", bus.stg_valid);
        end
        compared++;
        if (bus.fwd_a !== '0 || bus.fwd_b !== '0) begin
            mismatched++;
            $display("FAIL reset_fwd got %0d/%0d want 0/0", bus.fwd_a, bus.fwd_b);
        end
        compared++;
        if ({bus.pc_hold, bus.id_kill, bus.ex_bubble} !== 3'b000) begin
            mismatched++;
            $display("FAIL reset_ctl got %b want 000", {bus.pc_hold, bus.id_kill, bus.ex_bubble});
        end
        compared++;
        if (bus.lu_cnt !== 16'd0 || bus.fl_cnt !== 16'd0) begin
            mismatched++;
            $display("FAIL reset_cnt got %0d/%0d want 0/0", bus.lu_cnt, bus.fl_cnt);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive_id(1, 5, 1, 2, 0, 0, 1, 1);
        #1;
        compared++;
        if (bus.pc_hold !== 1'b0) begin
            mismatched++;
            $display("FAIL lu_no_stall_on_load got %b want 0", bus.pc_hold);
        end
        step();
        drive_id(1, 6, 5, 0, 1, 0, 1, 0);
        #1;
        compared++;
        if ({bus.pc_hold, bus.ex_bubble, bus.id_kill} !== 3'b110) begin
            mismatched++;
            $display("FAIL lu_stall got %b want 110", {bus.pc_hold, bus.ex_bubble, bus.id_kill});
        end
        step();
        #1;
        compared++;
        if ({bus.pc_hold, bus.ex_bubble} !== 2'b00) begin
            mismatched++;
            $display("FAIL lu_release got %b want 00", {bus.pc_hold, bus.ex_bubble});
        end
        step();
        idle();
        #1;
        compared++;
        if (bus.fwd_a !== SEL_W'(3) || bus.lu_cnt !== 16'd1) begin
            mismatched++;
            $display("FAIL lu_fwd_cnt got fwd_a=%0d lu=%0d want 3 1", bus.fwd_a, bus.lu_cnt);
        end
    endtask

    task automatic test_fwd_nearest();
        do_reset();
        drive_id(1, 7, 0, 0, 0, 0, 1, 0);
        step();
        drive_id(1, 7, 0, 0, 0, 0, 1, 0);
        step();
        drive_id(1, 9, 3, 7, 1, 1, 1, 0);
        step();
        idle();
        #1;
        compared++;
        if (bus.fwd_b !== SEL_W'(2) || bus.fwd_a !== '0) begin
            mismatched++;
            $display("FAIL fwd_nearest got a=%0d b=%0d want 0 2", bus.fwd_a, bus.fwd_b);
        end
        do_reset();
        drive_id(1, 7, 0, 0, 0, 0, 1, 0);
        step();
        drive_id(1, 7, 0, 0, 0, 0, 0, 0);
        step();
        drive_id(1, 9, 7, 4, 1, 1, 1, 0);
        step();
        idle();
        #1;
        compared++;
        if (bus.fwd_a !== SEL_W'(3) || bus.fwd_b !== '0) begin
            mismatched++;
            $display("FAIL fwd_far got a=%0d b=%0d want 3 0", bus.fwd_a, bus.fwd_b);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        set_ctl(1, 0);
        drive_id(1, 2, 0, 0, 0, 0, 1, 0);
        #1;
        compared++;
        if (bus.id_kill !== 1'b0) begin
            mismatched++;
            $display("FAIL redir_ignored got %b want 0", bus.id_kill);
        end
        do_reset();
        drive_id(1, 5, 0, 0, 0, 0, 1, 1);
        step();
        drive_id(1, 6, 5, 5, 1, 1, 1, 0);
        set_ctl(1, 0);
        #1;
        compared++;
        if ({bus.id_kill, bus.ex_bubble, bus.pc_hold} !== 3'b110) begin
            mismatched++;
            $display("FAIL redir_ctl got %b want 110", {bus.id_kill, bus.ex_bubble, bus.pc_hold});
        end
        step();
        idle();
        #1;
        compared++;
        if (bus.fl_cnt !== 16'd1 || bus.lu_cnt !== 16'd0 || bus.stg_valid !== 3'b010) begin
            mismatched++;
            $display("FAIL redir_cnt got fl=%0d lu=%0d sv=%b want 1 0 010",
                     bus.fl_cnt, bus.lu_cnt, bus.stg_valid);
        end
    endtask

    task automatic test_mem_busy();
        do_reset();
        drive_id(1, 5, 0, 0, 0, 0, 1, 1);
        step();
        drive_id(1, 6, 0, 5, 0, 1, 1, 0);
        set_ctl(0, 1);
        for (int i = 0; i < 4; i++) begin
            #1;
            compared++;
            if ({bus.pc_hold, bus.ex_bubble, bus.id_kill} !== 3'b100 ||
                bus.stg_valid !== 3'b001 || bus.lu_cnt !== 16'd0) begin
                mismatched++;
                $display("FAIL busy_freeze cyc %0d got ctl=%b sv=%b lu=%0d want 100 001 0", i,
                         {bus.pc_hold, bus.ex_bubble, bus.id_kill}, bus.stg_valid, bus.lu_cnt);
            end
            step();
        end
        set_ctl(0, 0);
        #1;
        compared++;
        if ({bus.pc_hold, bus.ex_bubble} !== 2'b11) begin
            mismatched++;
            $display("FAIL busy_release got %b want 11", {bus.pc_hold, bus.ex_bubble});
        end
        step();
        #1;
        compared++;
        if (bus.lu_cnt !== 16'd1 || bus.stg_valid !== 3'b010) begin
            mismatched++;
            $display("FAIL busy_lu_cnt got lu=%0d sv=%b want 1 010", bus.lu_cnt, bus.stg_valid);
        end
    endtask

    task automatic test_x0();
        do_reset();
        for (int i = 0; i < NSTG; i++) begin
            drive_id(1, 0, 0, 0, 0, 0, 1, 1);
            step();
        end
        drive_id(1, 0, 0, 0, 1, 1, 1, 0);
        #1;
        compared++;
        if ({bus.pc_hold, bus.ex_bubble} !== 2'b00) begin
            mismatched++;
            $display("FAIL x0_stall got %b want 00", {bus.pc_hold, bus.ex_bubble});
        end
        step();
        idle();
        #1;
        compared++;
        if (bus.fwd_a !== '0 || bus.fwd_b !== '0 || bus.lu_cnt !== 16'd0) begin
            mismatched++;
            $display("FAIL x0_fwd got a=%0d b=%0d lu=%0d want 0 0 0",
                     bus.fwd_a, bus.fwd_b, bus.lu_cnt);
        end
    endtask

    task automatic test_random();
        logic [VW-1:0] got;
        logic [VW-1:0] want;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            drive_id($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom),
                     1'($urandom));
            set_ctl($urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0);
            #1;
            got  = dut_vec();
            want = exp_vec();
            compared++;
            if (got !== want) begin
                mismatched++;
                $display("FAIL random cyc %0d got %h want %h", i, got, want);
            end
            step();
        end
        reset = 1'b0;
    endtask

    task automatic test_saturation();
        do_reset();
        drive_id(1, 5, 5, 0, 1, 0, 1, 1);
        set_ctl(0, 0);
        for (int i = 0; i < 2 * 65535; i++) step();
        #1;
        compared++;
        if (bus.lu_cnt !== 16'hFFFF) begin
            mismatched++;
            $display("FAIL sat_65535 got %h want ffff", bus.lu_cnt);
        end
        for (int n = 0; n < 2; n++) begin
            step();
            step();
            #1;
            compared++;
            if (bus.lu_cnt !== 16'hFFFF) begin
                mismatched++;
                $display("FAIL sat_hold extra %0d got %h want ffff", n + 1, bus.lu_cnt);
            end
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle();
        #1;
        compared++;
        if (bus.lu_cnt !== 16'd0 || bus.stg_valid !== '0) begin
            mismatched++;
            $display("FAIL sat_reset got lu=%h sv=%b want 0 0", bus.lu_cnt, bus.stg_valid);
        end
    endtask

    initial begin
        reset = 1'b1;
        idle();
        for (int k = 1; k <= NSTG; k++) mp[k] = '{default: 0};
        m_lu = 0;
        m_fl = 0;
        @(negedge clk);
        test_reset();
        test_load_use();
        test_fwd_nearest();
        test_redirect();
        test_mem_busy();
        test_x0();
        test_random();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
